// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM-stage controller: MIPS opcodes of interest
// and the access-sequencer state encoding.
package mem_ctrl_pkg;

  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_BLEZ = 6'h06;
  localparam logic [5:0] OP_BGTZ = 6'h07;
  // BLTZ and BGEZ share the REGIMM primary opcode; rt distinguishes them.
  localparam logic [5:0] OP_BLTZ = 6'h01;
  localparam logic [5:0] OP_BGEZ = 6'h01;
  localparam logic [5:0] OP_J    = 6'h02;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERR    = 2'd2
  } state_t;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// MEM-stage control bundle: instruction/forwarding inputs, memory handshake
// and the decoded strobes returned by the controller.
interface mem_stage_ctrl_if #(
  parameter int OP_W      = 6,
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2
);
  localparam int SRC_W = $clog2(FWD_DEPTH + 1);

  logic                        valid_in;
  logic [OP_W-1:0]             op_code;
  logic                        flush;
  logic [REG_AW-1:0]           store_rt;
  logic [FWD_DEPTH*REG_AW-1:0] fwd_dst;
  logic [FWD_DEPTH-1:0]        fwd_wen;
  logic                        mem_ready;
  logic                        branch;
  logic                        jump;
  logic                        mem_rd;
  logic                        mem_wr;
  logic [SRC_W-1:0]            mem_src;
  logic                        stall;
  logic                        err;

  modport master (
    output valid_in, op_code, flush, store_rt, fwd_dst, fwd_wen, mem_ready,
    input  branch, jump, mem_rd, mem_wr, mem_src, stall, err
  );

  modport slave (
    input  valid_in, op_code, flush, store_rt, fwd_dst, fwd_wen, mem_ready,
    output branch, jump, mem_rd, mem_wr, mem_src, stall, err
  );
endinterface

// File: rtl/mem_stage_ctrl_fwd_sel_prio.sv
// Store-data forwarding select: the nearest downstream stage writing the
// store source register wins; register 0 is never forwarded.
module fwd_sel_prio #(
  parameter int FWD_DEPTH = 2,
  parameter int REG_AW    = 5,
  parameter int SRC_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic [REG_AW-1:0]           store_rt,
  input  logic [FWD_DEPTH*REG_AW-1:0] fwd_dst,
  input  logic [FWD_DEPTH-1:0]        fwd_wen,
  output logic [SRC_W-1:0]            sel
);

  // Scan farthest to nearest so the lowest matching index overrides.
  always_comb begin
    sel = {SRC_W{1'b0}};
    for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
      if (fwd_wen[i] && (fwd_dst[i*REG_AW +: REG_AW] == store_rt) &&
          (store_rt != {REG_AW{1'b0}})) begin
        sel = SRC_W'(i + 1);
      end else begin
        sel = sel;
      end
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: decodes branch/jump/memory ops, sequences
// variable-latency memory accesses with stall, and flags access timeouts.
module mem_stage_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int OP_W      = 6,
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int MAX_WAIT  = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_stage_ctrl_if.slave bus
);

  localparam int SRC_W = $clog2(FWD_DEPTH + 1);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

  state_t           state_r;
  logic [CNT_W-1:0] wait_cnt_r;
  logic             branch_r;
  logic             jump_r;
  logic             mem_rd_r;
  logic             mem_wr_r;
  logic [SRC_W-1:0] mem_src_r;
  logic             err_r;

  logic             accept_s;
  logic             is_lw_s;
  logic             is_sw_s;
  logic             is_branch_s;
  logic             is_jump_s;
  logic             stall_s;
  logic [SRC_W-1:0] fwd_src_s;

  assign is_lw_s     = (bus.op_code == OP_W'(OP_LW));
  assign is_sw_s     = (bus.op_code == OP_W'(OP_SW));
  assign is_jump_s   = (bus.op_code == OP_W'(OP_J));
  assign is_branch_s = (bus.op_code == OP_W'(OP_BEQ))  || (bus.op_code == OP_W'(OP_BNE))  ||
                       (bus.op_code == OP_W'(OP_BLEZ)) || (bus.op_code == OP_W'(OP_BGTZ)) ||
                       (bus.op_code == OP_W'(OP_BLTZ)) || (bus.op_code == OP_W'(OP_BGEZ));
  assign accept_s    = (state_r == IDLE) && bus.valid_in && !bus.flush;

  fwd_sel_prio #(
    .FWD_DEPTH (FWD_DEPTH),
    .REG_AW    (REG_AW),
    .SRC_W     (SRC_W)
  ) u_fwd_sel (
    .store_rt (bus.store_rt),
    .fwd_dst  (bus.fwd_dst),
    .fwd_wen  (bus.fwd_wen),
    .sel      (fwd_src_s)
  );

  // Upstream freeze: from the accept cycle until the memory completes, and in ERR.
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      IDLE:    stall_s = accept_s && (is_lw_s || is_sw_s);
      ACCESS:  stall_s = !bus.mem_ready;
      ERR:     stall_s = 1'b1;
      default: stall_s = 1'b0;
    endcase
  end

  // Sequencer with registered strobes; flush cannot abort an issued access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      wait_cnt_r <= {CNT_W{1'b0}};
      branch_r   <= 1'b0;
      jump_r     <= 1'b0;
      mem_rd_r   <= 1'b0;
      mem_wr_r   <= 1'b0;
      mem_src_r  <= {SRC_W{1'b0}};
      err_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          branch_r   <= accept_s && is_branch_s;
          jump_r     <= accept_s && is_jump_s;
          mem_rd_r   <= accept_s && is_lw_s;
          mem_wr_r   <= accept_s && is_sw_s;
          mem_src_r  <= (accept_s && is_sw_s) ? fwd_src_s : {SRC_W{1'b0}};
          wait_cnt_r <= {CNT_W{1'b0}};
          err_r      <= 1'b0;
          if (accept_s && (is_lw_s || is_sw_s)) begin
            state_r <= ACCESS;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          branch_r <= 1'b0;
          jump_r   <= 1'b0;
          if (bus.mem_ready) begin
            state_r    <= IDLE;
            mem_rd_r   <= 1'b0;
            mem_wr_r   <= 1'b0;
            mem_src_r  <= {SRC_W{1'b0}};
            wait_cnt_r <= {CNT_W{1'b0}};
          end else if (wait_cnt_r == LAST_WAIT) begin
            state_r    <= ERR;
            mem_rd_r   <= 1'b0;
            mem_wr_r   <= 1'b0;
            mem_src_r  <= {SRC_W{1'b0}};
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
            err_r      <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
          end
        end
        ERR: begin
          branch_r  <= 1'b0;
          jump_r    <= 1'b0;
          mem_rd_r  <= 1'b0;
          mem_wr_r  <= 1'b0;
          mem_src_r <= {SRC_W{1'b0}};
          if (bus.flush) begin
            state_r    <= IDLE;
            err_r      <= 1'b0;
            wait_cnt_r <= {CNT_W{1'b0}};
          end else begin
            state_r <= ERR;
            err_r   <= 1'b1;
          end
        end
        default: begin
          state_r    <= IDLE;
          wait_cnt_r <= {CNT_W{1'b0}};
          branch_r   <= 1'b0;
          jump_r     <= 1'b0;
          mem_rd_r   <= 1'b0;
          mem_wr_r   <= 1'b0;
          mem_src_r  <= {SRC_W{1'b0}};
          err_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.branch  = branch_r;
  assign bus.jump    = jump_r;
  assign bus.mem_rd  = mem_rd_r;
  assign bus.mem_wr  = mem_wr_r;
  assign bus.mem_src = mem_src_r;
  assign bus.stall   = stall_s;
  assign bus.err     = err_r;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl; flags = {branch, jump, mem_rd, mem_wr, stall, err}.
module tb_mem_stage_ctrl;
  import mem_ctrl_pkg::*;

  localparam int OP_W      = 6;
  localparam int REG_AW    = 5;
  localparam int FWD_DEPTH = 2;
  localparam int MAX_WAIT  = 15;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  mem_stage_ctrl_if #(.OP_W(OP_W), .REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH)) bus ();

  mem_stage_ctrl #(
    .OP_W(OP_W), .REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [5:0] flags;
  assign flags = {bus.branch, bus.jump, bus.mem_rd, bus.mem_wr, bus.stall, bus.err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.valid_in  = 1'b0;
    bus.op_code   = 6'h00;
    bus.flush     = 1'b0;
    bus.store_rt  = 5'd0;
    bus.fwd_dst   = 10'h000;
    bus.fwd_wen   = 2'b00;
    bus.mem_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #3;
    checks++;
    if (flags !== 6'b000000 || bus.mem_src !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: flags=%b src=%0d required flags=000000 src=0", flags, bus.mem_src);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (flags !== 6'b000000) begin
      errors++;
      $display("FAIL reset_release: flags=%b required 000000", flags);
    end
  endtask

  task automatic test_lw_zero_wait();
    bus.valid_in = 1'b1; bus.op_code = OP_LW; bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (flags !== 6'b000010) begin
      errors++;
      $display("FAIL lw0_accept: flags=%b required 000010", flags);
    end
    step();
    bus.valid_in = 1'b0;
    #1;
    checks++;
    if (flags !== 6'b001000) begin
      errors++;
      $display("FAIL lw0_access: flags=%b required 001000", flags);
    end
    step();
    checks++;
    if (flags !== 6'b000000) begin
      errors++;
      $display("FAIL lw0_done: flags=%b required 000000", flags);
    end
  endtask

  task automatic test_fwd_select();
    logic [4:0] rt_t  [4] = '{5'd5, 5'd5, 5'd0, 5'd5};
    logic [9:0] dst_t [4] = '{10'h0A5, 10'h0A5, 10'h000, 10'h0A3};
    logic [1:0] wen_t [4] = '{2'b11, 2'b10, 2'b11, 2'b11};
    logic [1:0] exp_t [4] = '{2'd1, 2'd2, 2'd0, 2'd2};
    for (int i = 0; i < 4; i++) begin
      bus.store_rt = rt_t[i]; bus.fwd_dst = dst_t[i]; bus.fwd_wen = wen_t[i];
      bus.valid_in = 1'b1; bus.op_code = OP_SW; bus.mem_ready = 1'b1;
      step();
      bus.valid_in = 1'b0; bus.fwd_wen = 2'b00;
      #1;
      checks++;
      if (bus.mem_src !== exp_t[i] || flags !== 6'b000100) begin
        errors++;
        $display("FAIL fwd_sel[%0d]: src=%0d flags=%b required src=%0d flags=000100",
                 i, bus.mem_src, flags, exp_t[i]);
      end
      step();
      checks++;
      if (bus.mem_src !== 2'd0 || flags !== 6'b000000) begin
        errors++;
        $display("FAIL fwd_done[%0d]: src=%0d flags=%b required src=0 flags=000000",
                 i, bus.mem_src, flags);
      end
    end
    idle_inputs();
  endtask

  task automatic test_lw_delayed();
    int stall_cycles = 0;
    bus.valid_in = 1'b1; bus.op_code = OP_LW; bus.mem_ready = 1'b0;
    #1;
    if (bus.stall === 1'b1) stall_cycles++;
    step();
    bus.valid_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.mem_ready = (k == 3);
      bus.flush     = (k == 1);
      bus.store_rt  = 5'd9; bus.fwd_dst = 10'h129; bus.fwd_wen = 2'b01;
      #1;
      if (bus.stall === 1'b1) stall_cycles++;
      checks++;
      if (flags !== {4'b0010, (k != 3), 1'b0} || bus.mem_src !== 2'd0) begin
        errors++;
        $display("FAIL lw_wait[%0d]: flags=%b src=%0d required flags=%b src=0",
                 k, flags, bus.mem_src, {4'b0010, (k != 3), 1'b0});
      end
      step();
    end
    idle_inputs();
    #1;
    checks++;
    if (flags !== 6'b000000) begin
      errors++;
      $display("FAIL lw_wait_done: flags=%b required 000000", flags);
    end
    checks++;
    if (stall_cycles !== 4) begin
      errors++;
      $display("FAIL lw_wait_stall_cycles: got %0d required 4", stall_cycles);
    end
  endtask

  task automatic test_timeout();
    bus.store_rt = 5'd7; bus.fwd_dst = 10'h0E7; bus.fwd_wen = 2'b01;
    bus.valid_in = 1'b1; bus.op_code = OP_SW; bus.mem_ready = 1'b0;
    step();
    bus.valid_in = 1'b0; bus.fwd_wen = 2'b10;
    for (int k = 1; k <= MAX_WAIT; k++) begin
      checks++;
      if (flags !== 6'b000110 || bus.mem_src !== 2'd1) begin
        errors++;
        $display("FAIL timeout_access[%0d]: flags=%b src=%0d required flags=000110 src=1",
                 k, flags, bus.mem_src);
      end
      step();
    end
    checks++;
    if (flags !== 6'b000011 || bus.mem_src !== 2'd0) begin
      errors++;
      $display("FAIL timeout_err: flags=%b src=%0d required flags=000011 src=0", flags, bus.mem_src);
    end
    step();
    checks++;
    if (flags !== 6'b000011) begin
      errors++;
      $display("FAIL timeout_sticky: flags=%b required 000011", flags);
    end
    bus.flush = 1'b1;
    #1;
    checks++;
    if (flags !== 6'b000011) begin
      errors++;
      $display("FAIL timeout_flush_same_cycle: flags=%b required 000011", flags);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (flags !== 6'b000000) begin
      errors++;
      $display("FAIL timeout_cleared: flags=%b required 000000", flags);
    end
  endtask

  task automatic test_branch_jump();
    bus.valid_in = 1'b1; bus.op_code = OP_BEQ;
    #1;
    checks++;
    if (flags !== 6'b000000) begin
      errors++;
      $display("FAIL beq_accept: flags=%b required 000000", flags);
    end
    step();
    bus.op_code = OP_J;
    #1;
    checks++;
    if (flags !== 6'b100000) begin
      errors++;
      $display("FAIL beq_pulse: flags=%b required 100000", flags);
    end
    step();
    bus.op_code = OP_BLTZ;
    checks++;
    if (flags !== 6'b010000) begin
      errors++;
      $display("FAIL j_pulse: flags=%b required 010000", flags);
    end
    step();
    bus.op_code = 6'h00;
    checks++;
    if (flags !== 6'b100000) begin
      errors++;
      $display("FAIL bltz_pulse: flags=%b required 100000", flags);
    end
    step();
    bus.valid_in = 1'b0;
    checks++;
    if (flags !== 6'b000000) begin
      errors++;
      $display("FAIL rtype_no_strobe: flags=%b required 000000", flags);
    end
    bus.valid_in = 1'b1; bus.flush = 1'b1; bus.op_code = OP_BEQ;
    step();
    bus.op_code = OP_LW;
    #1;
    checks++;
    if (flags !== 6'b000000) begin
      errors++;
      $display("FAIL flush_beq_lw: flags=%b required 000000", flags);
    end
    step();
    idle_inputs();
    checks++;
    if (flags !== 6'b000000) begin
      errors++;
      $display("FAIL flush_lw_no_access: flags=%b required 000000", flags);
    end
  endtask

  task automatic test_back_to_back();
    bus.valid_in = 1'b1; bus.op_code = OP_LW; bus.mem_ready = 1'b1;
    step();
    bus.op_code = OP_SW; bus.store_rt = 5'd3; bus.fwd_dst = 10'h003; bus.fwd_wen = 2'b01;
    #1;
    checks++;
    if (flags !== 6'b001000) begin
      errors++;
      $display("FAIL b2b_lw_access: flags=%b required 001000", flags);
    end
    step();
    checks++;
    if (flags !== 6'b000010) begin
      errors++;
      $display("FAIL b2b_sw_accept: flags=%b required 000010", flags);
    end
    step();
    bus.valid_in = 1'b0;
    checks++;
    if (flags !== 6'b000100 || bus.mem_src !== 2'd1) begin
      errors++;
      $display("FAIL b2b_sw_access: flags=%b src=%0d required flags=000100 src=1", flags, bus.mem_src);
    end
    step();
    idle_inputs();
    checks++;
    if (flags !== 6'b000000) begin
      errors++;
      $display("FAIL b2b_done: flags=%b required 000000", flags);
    end
  endtask

  task automatic test_reset_mid_access();
    bus.valid_in = 1'b1; bus.op_code = OP_LW; bus.mem_ready = 1'b0;
    step();
    bus.valid_in = 1'b0;
    #1;
    checks++;
    if (flags !== 6'b001010) begin
      errors++;
      $display("FAIL rst_pre_access: flags=%b required 001010", flags);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (flags !== 6'b000000 || bus.mem_src !== 2'd0) begin
      errors++;
      $display("FAIL rst_async_clear: flags=%b src=%0d required flags=000000 src=0", flags, bus.mem_src);
    end
    #2;
    rst_n = 1'b1;
    step();
    bus.valid_in = 1'b1; bus.op_code = OP_LW; bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (flags !== 6'b000010) begin
      errors++;
      $display("FAIL rst_relaunch_accept: flags=%b required 000010", flags);
    end
    step();
    bus.valid_in = 1'b0;
    checks++;
    if (flags !== 6'b001000) begin
      errors++;
      $display("FAIL rst_relaunch_access: flags=%b required 001000", flags);
    end
    step();
    checks++;
    if (flags !== 6'b000000) begin
      errors++;
      $display("FAIL rst_relaunch_done: flags=%b required 000000", flags);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_lw_zero_wait();
    test_fwd_select();
    test_lw_delayed();
    test_timeout();
    test_branch_jump();
    test_back_to_back();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
